// File: rtl/distributed_fifo_v2.sv
// distributed_fifo_v2: ready/valid FIFO with arbitrary depth, level, threshold flags, flush and optional output register
module distributed_fifo_v2 #(
    parameter int WIDTH         = 8,
    parameter int DEPTH         = 512,
    parameter int AFULL_THRESH  = DEPTH - 2,
    parameter int AEMPTY_THRESH = 1,
    parameter int OUTPUT_REG    = 0
) (
    input  logic                       i_clock,
    input  logic                       i_reset,
    input  logic [WIDTH-1:0]           i_in_data,
    input  logic                       i_in_valid,
    output logic                       o_in_ready,
    output logic [WIDTH-1:0]           o_out_data,
    output logic                       o_out_valid,
    input  logic                       i_out_ready,
    input  logic                       i_flush,
    output logic [$clog2(DEPTH+1)-1:0] o_level,
    output logic                       o_almost_full,
    output logic                       o_almost_empty
);
    localparam int R  = DEPTH - OUTPUT_REG;
    localparam int PW = R > 1 ? $clog2(R) : 1;
    localparam int LW = $clog2(DEPTH + 1);
    localparam logic [1:0] INIT = 2'd0, EMPTY = 2'd1, NORMAL = 2'd2, FULL = 2'd3;

    logic [1:0]       state;
    logic [WIDTH-1:0] mem [R];
    logic [PW-1:0]    wptr, rptr;
    logic [LW-1:0]    level, ram_cnt, nl;
    logic [WIDTH-1:0] dout;
    logic             ov, wr, rd, pop;

    assign o_in_ready  = state == EMPTY || state == NORMAL;
    assign o_out_valid = OUTPUT_REG != 0 ? ov : level != '0;
    assign o_out_data  = OUTPUT_REG != 0 ? dout : mem[rptr];
    assign o_level     = level;
    assign wr          = i_in_valid && o_in_ready;
    assign rd          = o_out_valid && i_out_ready;
    // pop advances the RAM read side: a consumer read, or an output-register refill
    assign pop         = OUTPUT_REG != 0 ? (!ov || rd) && ram_cnt != '0 : rd;
    assign nl          = level + LW'(wr) - LW'(rd);

    always_ff @(posedge i_clock) begin
        if (wr)
            mem[wptr] <= i_in_data;
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state          <= INIT;
            wptr           <= '0;
            rptr           <= '0;
            level          <= '0;
            ram_cnt        <= '0;
            ov             <= 1'b0;
            dout           <= '0;
            o_almost_full  <= 1'b0;
            o_almost_empty <= 1'b1;
        end else if (i_flush) begin
            state          <= EMPTY;
            wptr           <= '0;
            rptr           <= '0;
            level          <= '0;
            ram_cnt        <= '0;
            ov             <= 1'b0;
            dout           <= '0;
            o_almost_full  <= 1'b0;
            o_almost_empty <= 1'b1;
        end else begin
            if (wr)
                wptr <= wptr == PW'(R - 1) ? '0 : wptr + 1'b1;
            if (pop)
                rptr <= rptr == PW'(R - 1) ? '0 : rptr + 1'b1;
            if (OUTPUT_REG != 0 && pop)
                dout <= mem[rptr];
            ov             <= pop || (ov && !rd);
            level          <= nl;
            ram_cnt        <= ram_cnt + LW'(wr) - LW'(pop);
            o_almost_full  <= nl >= LW'(AFULL_THRESH);
            o_almost_empty <= nl <= LW'(AEMPTY_THRESH);
            state          <= nl == '0 ? EMPTY : nl == LW'(DEPTH) ? FULL : NORMAL;
        end
    end
endmodule

// File: tb/tb_distributed_fifo_v2.sv
// tb_distributed_fifo_v2: directed tests over three configurations (5/plain, 8/thresholds, 6/output register)
module tb_distributed_fifo_v2;
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst;

    logic [7:0] a_in_data, a_out_data;
    logic       a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_flush, a_af, a_ae;
    logic [2:0] a_level;
    logic [7:0] b_in_data, b_out_data;
    logic       b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_flush, b_af, b_ae;
    logic [3:0] b_level;
    logic [7:0] c_in_data, c_out_data;
    logic       c_in_valid, c_in_ready, c_out_valid, c_out_ready, c_flush, c_af, c_ae;
    logic [2:0] c_level;

    int n_chk = 0;
    int n_fail = 0;

    distributed_fifo_v2 #(.WIDTH(8), .DEPTH(5), .AFULL_THRESH(3), .AEMPTY_THRESH(1), .OUTPUT_REG(0)) u_a (
        .i_clock(clk), .i_reset(rst), .i_in_data(a_in_data), .i_in_valid(a_in_valid), .o_in_ready(a_in_ready),
        .o_out_data(a_out_data), .o_out_valid(a_out_valid), .i_out_ready(a_out_ready), .i_flush(a_flush),
        .o_level(a_level), .o_almost_full(a_af), .o_almost_empty(a_ae));
    distributed_fifo_v2 #(.WIDTH(8), .DEPTH(8), .AFULL_THRESH(6), .AEMPTY_THRESH(2), .OUTPUT_REG(0)) u_b (
        .i_clock(clk), .i_reset(rst), .i_in_data(b_in_data), .i_in_valid(b_in_valid), .o_in_ready(b_in_ready),
        .o_out_data(b_out_data), .o_out_valid(b_out_valid), .i_out_ready(b_out_ready), .i_flush(b_flush),
        .o_level(b_level), .o_almost_full(b_af), .o_almost_empty(b_ae));
    distributed_fifo_v2 #(.WIDTH(8), .DEPTH(6), .AFULL_THRESH(4), .AEMPTY_THRESH(1), .OUTPUT_REG(1)) u_c (
        .i_clock(clk), .i_reset(rst), .i_in_data(c_in_data), .i_in_valid(c_in_valid), .o_in_ready(c_in_ready),
        .o_out_data(c_out_data), .o_out_valid(c_out_valid), .i_out_ready(c_out_ready), .i_flush(c_flush),
        .o_level(c_level), .o_almost_full(c_af), .o_almost_empty(c_ae));

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) step();
        n_chk++; if (a_in_ready !== 1'b0) begin n_fail++; $display("FAIL rst_a_ready got %b want 0", a_in_ready); end
        n_chk++; if (a_out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_a_valid got %b want 0", a_out_valid); end
        n_chk++; if (a_level !== 3'd0) begin n_fail++; $display("FAIL rst_a_level got %0d want 0", a_level); end
        n_chk++; if (a_ae !== 1'b1 || a_af !== 1'b0) begin n_fail++; $display("FAIL rst_a_flags got ae=%b af=%b want ae=1 af=0", a_ae, a_af); end
        n_chk++; if (b_ae !== 1'b1 || b_af !== 1'b0 || b_level !== 4'd0) begin n_fail++; $display("FAIL rst_b got ae=%b af=%b lvl=%0d want 1 0 0", b_ae, b_af, b_level); end
        n_chk++; if (c_out_data !== 8'h00 || c_out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_c_out got %h/%b want 00/0", c_out_data, c_out_valid); end
        rst = 1'b0;
        n_chk++; if (a_in_ready !== 1'b0) begin n_fail++; $display("FAIL init_ready got %b want 0", a_in_ready); end
        step();
        n_chk++; if (a_in_ready !== 1'b1 || b_in_ready !== 1'b1 || c_in_ready !== 1'b1) begin n_fail++; $display("FAIL post_init_ready got %b%b%b want 111", a_in_ready, b_in_ready, c_in_ready); end
        n_chk++; if (a_out_valid !== 1'b0 || a_level !== 3'd0) begin n_fail++; $display("FAIL post_init_a got v=%b l=%0d want 0 0", a_out_valid, a_level); end
    endtask

    task automatic test_fill_drain();
        a_out_ready = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            a_in_data = 8'(i); a_in_valid = 1'b1;
            step();
            n_chk++; if (a_level !== 3'(i)) begin n_fail++; $display("FAIL fill_level got %0d want %0d", a_level, i); end
            n_chk++; if (a_in_ready !== (i < 5)) begin n_fail++; $display("FAIL fill_ready got %b want %b at %0d", a_in_ready, i < 5, i); end
        end
        a_in_data = 8'h06;
        step();
        n_chk++; if (a_level !== 3'd5 || a_in_ready !== 1'b0) begin n_fail++; $display("FAIL hold6 got l=%0d r=%b want 5 0", a_level, a_in_ready); end
        a_in_valid = 1'b0; a_out_ready = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            n_chk++; if (a_out_valid !== 1'b1 || a_out_data !== 8'(i)) begin n_fail++; $display("FAIL drain_data got %h/%b want %h/1", a_out_data, a_out_valid, 8'(i)); end
            step();
            n_chk++; if (a_level !== 3'(5 - i)) begin n_fail++; $display("FAIL drain_level got %0d want %0d", a_level, 5 - i); end
        end
        n_chk++; if (a_out_valid !== 1'b0) begin n_fail++; $display("FAIL drain_empty got %b want 0", a_out_valid); end
        a_out_ready = 1'b0;
    endtask

    task automatic test_full_simul();
        for (int i = 0; i < 5; i++) begin
            a_in_data = 8'(8'h10 + i); a_in_valid = 1'b1;
            step();
        end
        a_in_data = 8'h15; a_out_ready = 1'b1;
        n_chk++; if (a_in_ready !== 1'b0 || a_out_data !== 8'h10) begin n_fail++; $display("FAIL full_pre got r=%b d=%h want 0 10", a_in_ready, a_out_data); end
        step();
        n_chk++; if (a_level !== 3'd4 || a_in_ready !== 1'b1 || a_out_data !== 8'h11) begin n_fail++; $display("FAIL full_simul got l=%0d r=%b d=%h want 4 1 11", a_level, a_in_ready, a_out_data); end
        a_out_ready = 1'b0;
        step();
        n_chk++; if (a_level !== 3'd5 || a_in_ready !== 1'b0) begin n_fail++; $display("FAIL full_refill got l=%0d r=%b want 5 0", a_level, a_in_ready); end
        a_in_valid = 1'b0; a_out_ready = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            n_chk++; if (a_out_data !== 8'(8'h10 + k)) begin n_fail++; $display("FAIL full_order got %h want %h", a_out_data, 8'(8'h10 + k)); end
            step();
        end
        n_chk++; if (a_out_valid !== 1'b0 || a_level !== 3'd0) begin n_fail++; $display("FAIL full_end got v=%b l=%0d want 0 0", a_out_valid, a_level); end
    endtask

    task automatic test_back_to_back();
        a_out_ready = 1'b1; a_in_valid = 1'b1;
        for (int k = 0; k < 20; k++) begin
            a_in_data = 8'(8'h40 + k);
            if (k > 0) begin
                n_chk++; if (a_out_valid !== 1'b1 || a_out_data !== 8'(8'h40 + k - 1) || a_level !== 3'd1) begin n_fail++; $display("FAIL stream got v=%b d=%h l=%0d want 1 %h 1", a_out_valid, a_out_data, a_level, 8'(8'h40 + k - 1)); end
            end
            step();
        end
        a_in_valid = 1'b0;
        n_chk++; if (a_out_data !== 8'h53 || a_level !== 3'd1) begin n_fail++; $display("FAIL stream_last got d=%h l=%0d want 53 1", a_out_data, a_level); end
        step();
        n_chk++; if (a_out_valid !== 1'b0 || a_level !== 3'd0) begin n_fail++; $display("FAIL stream_end got v=%b l=%0d want 0 0", a_out_valid, a_level); end
        a_out_ready = 1'b0;
    endtask

    task automatic test_thresholds();
        b_out_ready = 1'b0;
        for (int i = 1; i <= 7; i++) begin
            b_in_data = 8'(i); b_in_valid = 1'b1;
            step();
            n_chk++; if (b_level !== 4'(i) || b_af !== (i >= 6) || b_ae !== (i <= 2)) begin n_fail++; $display("FAIL thr_up got l=%0d af=%b ae=%b want %0d %b %b", b_level, b_af, b_ae, i, i >= 6, i <= 2); end
        end
        b_in_valid = 1'b0; b_out_ready = 1'b1;
        for (int j = 1; j <= 7; j++) begin
            n_chk++; if (b_out_data !== 8'(j)) begin n_fail++; $display("FAIL thr_data got %h want %h", b_out_data, 8'(j)); end
            step();
            n_chk++; if (b_level !== 4'(7 - j) || b_af !== (7 - j >= 6) || b_ae !== (7 - j <= 2)) begin n_fail++; $display("FAIL thr_down got l=%0d af=%b ae=%b want %0d %b %b", b_level, b_af, b_ae, 7 - j, 7 - j >= 6, 7 - j <= 2); end
        end
        b_out_ready = 1'b0;
    endtask

    task automatic test_flush_outreg();
        c_out_ready = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            c_in_data = 8'(i); c_in_valid = 1'b1;
            step();
        end
        n_chk++; if (c_level !== 3'd4 || c_out_valid !== 1'b1 || c_out_data !== 8'h01) begin n_fail++; $display("FAIL oreg_fill got l=%0d v=%b d=%h want 4 1 01", c_level, c_out_valid, c_out_data); end
        c_flush = 1'b1; c_in_data = 8'h77;
        step();
        c_flush = 1'b0; c_in_valid = 1'b0;
        n_chk++; if (c_level !== 3'd0 || c_out_valid !== 1'b0 || c_ae !== 1'b1 || c_in_ready !== 1'b1) begin n_fail++; $display("FAIL flush got l=%0d v=%b ae=%b r=%b want 0 0 1 1", c_level, c_out_valid, c_ae, c_in_ready); end
        c_in_data = 8'hAA; c_in_valid = 1'b1;
        step();
        c_in_valid = 1'b0;
        n_chk++; if (c_out_valid !== 1'b0 || c_level !== 3'd1) begin n_fail++; $display("FAIL oreg_lat1 got v=%b l=%0d want 0 1", c_out_valid, c_level); end
        step();
        n_chk++; if (c_out_valid !== 1'b1 || c_out_data !== 8'hAA) begin n_fail++; $display("FAIL oreg_lat2 got v=%b d=%h want 1 aa", c_out_valid, c_out_data); end
        c_out_ready = 1'b1;
        step();
        n_chk++; if (c_out_valid !== 1'b0 || c_level !== 3'd0) begin n_fail++; $display("FAIL oreg_read got v=%b l=%0d want 0 0", c_out_valid, c_level); end
        c_out_ready = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        a_in_data = '0; a_in_valid = 1'b0; a_out_ready = 1'b0; a_flush = 1'b0;
        b_in_data = '0; b_in_valid = 1'b0; b_out_ready = 1'b0; b_flush = 1'b0;
        c_in_data = '0; c_in_valid = 1'b0; c_out_ready = 1'b0; c_flush = 1'b0;
        test_reset();
        test_fill_drain();
        test_full_simul();
        test_back_to_back();
        test_thresholds();
        test_flush_outreg();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
